serial_frame_rx: RTL and testbench

//  Framed serial receiver; consumes the 1-bit line driven by the Serializer.

---
 rtl/serial_frame_rx.sv | 122 ++++++++++++
 tb/tb_serial_frame_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: hunts for a start bit, shifts in 2**LOGWIDTH bits LSB first,
// and buffers the word behind a Valid/Accept handshake. Optional parity check: PARITY_EN.
module serial_frame_rx #(
    parameter int LOGWIDTH = 5
) (
    input  logic                     Clk,
    input  logic                     Srst,
    input  logic                     In,
    output logic [2**LOGWIDTH-1:0]   Out,
    output logic                     Valid,
    input  logic                     Accept,
    output logic                     ParityErr,
    output logic                     Overrun,
    output logic                     Busy
);

    localparam int W = 2**LOGWIDTH;

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

    state_t              state_q, state_d;
    logic [LOGWIDTH-1:0] ind_q, ind_d;
    logic [W-1:0]        shift_q, shift_d;
    logic [W-1:0]        out_q, out_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ovr_q, ovr_d;

    logic                complete;
    logic [W-1:0]        word;
    logic                word_perr;

    // Frame FSM: produces a one-cycle completion strobe with the finished word.
    always_comb begin
        state_d   = state_q;
        ind_d     = ind_q;
        shift_d   = shift_q;
        complete  = 1'b0;
        word      = shift_q;
        word_perr = 1'b0;
        case (state_q)
            IDLE: begin
                if (In) begin
                    state_d = DATA;
                    ind_d   = '0;
                end
            end
            DATA: begin
                shift_d = {In, shift_q[W-1:1]};
                ind_d   = ind_q + LOGWIDTH'(1);
                if (&ind_q) begin
`ifdef PARITY_EN
                    state_d = PAR;
`else
                    complete = 1'b1;
                    word     = shift_d;
                    state_d  = IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: begin
                complete  = 1'b1;
                word      = shift_q;
                word_perr = In ^ (^shift_q);
                state_d   = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // One-entry buffer: a word finishing while the previous one is unconsumed is dropped.
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (complete) begin
            if (!valid_q || Accept) begin
                out_d   = word;
                perr_d  = word_perr;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && Accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Srst) begin
            state_q <= IDLE;
            ind_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ind_q   <= ind_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Out       = out_q;
    assign Valid     = valid_q;
    assign ParityErr = perr_q;
    assign Overrun   = ovr_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: an 8-bit instance for most scenarios and a
// 32-bit instance for a wide word; both share clock and reset.
module tb_serial_frame_rx;

    logic        Clk = 1'b0;
    logic        Srst;
    logic        In, In2;
    logic        Accept, Accept2;
    logic [7:0]  Out;
    logic [31:0] Out2;
    logic        Valid, Valid2, ParityErr, ParityErr2, Overrun, Overrun2, Busy, Busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    serial_frame_rx #(.LOGWIDTH(3)) dut (
        .Clk(Clk), .Srst(Srst), .In(In), .Out(Out), .Valid(Valid), .Accept(Accept),
        .ParityErr(ParityErr), .Overrun(Overrun), .Busy(Busy)
    );

    serial_frame_rx #(.LOGWIDTH(5)) dut32 (
        .Clk(Clk), .Srst(Srst), .In(In2), .Out(Out2), .Valid(Valid2), .Accept(Accept2),
        .ParityErr(ParityErr2), .Overrun(Overrun2), .Busy(Busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge so the DUT samples them cleanly on the rising edge.
    task automatic tick(input logic b, input logic acc);
        @(negedge Clk);
        In     = b;
        Accept = acc;
    endtask

    task automatic send_body(input logic [7:0] w, input logic pbit);
        for (int i = 0; i < 8; i++) tick(w[i], 1'b0);
`ifdef PARITY_EN
        tick(pbit, 1'b0);
`else
        if (pbit) ; // parity bit not part of the frame in this build
`endif
    endtask

    task automatic send_frame(input logic [7:0] w, input logic pbit);
        tick(1'b1, 1'b0);
        send_body(w, pbit);
    endtask

    task automatic send_frame32(input logic [31:0] w, input logic pbit);
        @(negedge Clk);
        In2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk);
            In2 = w[i];
        end
`ifdef PARITY_EN
        @(negedge Clk);
        In2 = pbit;
`else
        if (pbit) ;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        Srst = 1'b1; In = 1'b0; In2 = 1'b0; Accept = 1'b0; Accept2 = 1'b0;

        // 1: reset state and idle line
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Srst = 1'b0;
        chk("rst_out", Out, 0);
        chk("rst_valid", Valid, 0);
        chk("rst_perr", ParityErr, 0);
        chk("rst_ovr", Overrun, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_out32", Out2, 0);
        chk("rst_valid32", Valid2, 0);
        chk("rst_busy32", Busy2, 0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            chk("idle_busy", Busy, 0);
            chk("idle_valid", Valid, 0);
        end

        // 2: single word, held until accepted
        send_frame(8'hA5, 1'b0);
        idle(1);
        chk("a5_out", Out, 8'hA5);
        chk("a5_valid", Valid, 1);
        chk("a5_perr", ParityErr, 0);
        chk("a5_busy", Busy, 0);
        idle(5);
        chk("a5_hold_out", Out, 8'hA5);
        chk("a5_hold_valid", Valid, 1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("a5_acc_valid", Valid, 0);
        chk("a5_keep_out", Out, 8'hA5);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("acc_noval_valid", Valid, 0);

        // 3: back-to-back frames, accept pulsed right after Valid rises
        send_frame(8'h3C, 1'b0);
        @(negedge Clk);
        chk("b2b_first_out", Out, 8'h3C);
        chk("b2b_first_valid", Valid, 1);
        In = 1'b1; Accept = 1'b1;
        send_body(8'hC3, 1'b0);
        idle(1);
        chk("b2b_second_out", Out, 8'hC3);
        chk("b2b_second_valid", Valid, 1);
        chk("b2b_ovr", Overrun, 0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("b2b_drain", Valid, 0);

        // 4: overrun when the buffer is full
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        idle(1);
        chk("ovr_out", Out, 8'h11);
        chk("ovr_valid", Valid, 1);
        chk("ovr_flag", Overrun, 1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("ovr_acc_valid", Valid, 0);
        chk("ovr_sticky", Overrun, 1);
        idle(3);
        chk("ovr_sticky2", Overrun, 1);

`ifdef PARITY_EN
        // 5: parity error flagged, word still delivered
        send_frame(8'hA5, 1'b1);
        idle(1);
        chk("par_bad_out", Out, 8'hA5);
        chk("par_bad_valid", Valid, 1);
        chk("par_bad_flag", ParityErr, 1);
        tick(1'b0, 1'b1);
        send_frame(8'hA5, 1'b0);
        idle(1);
        chk("par_good_out", Out, 8'hA5);
        chk("par_good_flag", ParityErr, 0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
`endif

        // 6: reset mid-frame aborts, then a clean frame arrives
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        @(negedge Clk);
        chk("mid_busy", Busy, 1);
        In = 1'b0;
        Srst = 1'b1;
        @(negedge Clk);
        Srst = 1'b0;
        chk("abort_busy", Busy, 0);
        chk("abort_ovr", Overrun, 0);
        chk("abort_valid", Valid, 0);
        send_frame(8'h5A, 1'b0);
        idle(1);
        chk("post_abort_out", Out, 8'h5A);
        chk("post_abort_valid", Valid, 1);
        chk("post_abort_perr", ParityErr, 0);

        // Wide instance
        send_frame32(32'hDEADBEEF, 1'b0);
        @(negedge Clk);
        In2 = 1'b0;
        chk("w32_out", Out2, 32'hDEADBEEF);
        chk("w32_valid", Valid2, 1);
        chk("w32_perr", ParityErr2, 0);
        chk("w32_ovr", Overrun2, 0);
        chk("w32_busy", Busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
